// File: rtl/csr_pkg.sv
// Shared CSR addresses, cause codes, privilege encoding and mstatus layout.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   typedef enum logic [1:0] {PRIV_U = 2'b00, PRIV_M = 2'b11} mode_t;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;

   localparam logic [4:0] IRQ_MSI = 5'd3;
   localparam logic [4:0] IRQ_MTI = 5'd7;
   localparam logic [4:0] IRQ_MEI = 5'd11;

   // RV32 (MXL=1), I, M, U
   localparam logic [31:0] MISA_VAL = 32'h4010_1100;

   function automatic logic csr_implemented(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
         CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
         CSR_MINSTRETH, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID,
         CSR_MHARTID: return 1'b1;
         default:     return 1'b0;
      endcase
   endfunction

   // Implemented mip/mie bits: MSI, MTI, MEI plus n platform lines from bit 16.
   function automatic logic [31:0] irq_impl_mask(input int unsigned n);
      logic [31:0] m;
      m = 32'h0000_0888;
      for (int i = 0; i < 16; i++) begin
         if (i < n) m[16+i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit up-counter whose halves can be overwritten; a write suppresses the increment.
module csr_counter64 (
   input  logic        clk,
   input  logic        nrst,
   input  logic        inc,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [31:0] wdata,
   output logic [63:0] count
);

   // half replacement wins over counting in the same cycle
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count <= '0;
      end else if (we_lo || we_hi) begin
         if (we_lo) count[31:0]  <= wdata;
         if (we_hi) count[63:32] <= wdata;
      end else if (inc) begin
         count <= count + 64'd1;
      end
   end

endmodule

// File: rtl/csr_machine_file.sv
// Machine-mode CSR file with interrupt selection, trap entry, mret and fetch redirect.
module csr_machine_file
   import csr_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NUM_LOCAL = 4,
   parameter bit VECTORED  = 1'b1,
   parameter bit HAS_COUNT = 1'b1
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic [11:0]          csr_raddr,
   output logic [XLEN-1:0]      csr_rdata,
   output logic                 csr_illegal,
   input  logic                 csr_we,
   input  logic [11:0]          csr_waddr,
   input  logic [XLEN-1:0]      csr_wdata,
   input  logic                 retire,
   input  logic                 trap_req,
   input  logic [4:0]           trap_cause,
   input  logic [XLEN-1:0]      trap_pc,
   input  logic [XLEN-1:0]      trap_tval,
   input  logic                 mret,
   input  logic                 irq_ext,
   input  logic                 irq_timer,
   input  logic                 irq_soft,
   input  logic [(NUM_LOCAL>0 ? NUM_LOCAL : 1)-1:0] irq_local,
   output logic                 redirect_valid,
   output logic [XLEN-1:0]      redirect_pc,
   output logic                 irq_pending,
   output mode_t                priv_mode
);

   localparam logic [XLEN-1:0] IRQ_MASK   = irq_impl_mask(NUM_LOCAL);
   localparam logic [XLEN-1:0] MTVEC_MASK = VECTORED ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
   localparam logic [XLEN-1:0] EPC_MASK   = 32'hFFFF_FFFC;

   mode_t           priv_q, st_mpp;
   logic            st_mie, st_mpie;
   logic [XLEN-1:0] mie_q, mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
   logic [XLEN-1:0] mip, enabled, mstatus_rd, base;
   logic [4:0]      irq_cause;
   logic            irq_take, mret_take, wr_bad, wr_ok;
   logic [63:0]     cycle, instret;

   assign priv_mode = priv_q;

   // live interrupt lines and the winning enabled cause
   always_comb begin
      mip = '0;
      mip[IRQ_MEI] = irq_ext;
      mip[IRQ_MTI] = irq_timer;
      mip[IRQ_MSI] = irq_soft;
      for (int i = 0; i < NUM_LOCAL; i++) mip[16+i] = irq_local[i];
      enabled = mip & mie_q & {XLEN{st_mie | (priv_q == PRIV_U)}};
      // later assignments override earlier ones, so the order encodes priority
      irq_cause = '0;
      for (int i = 16; i < 32; i++) begin
         if (enabled[i]) irq_cause = 5'(i);
      end
      if (enabled[IRQ_MTI]) irq_cause = IRQ_MTI;
      if (enabled[IRQ_MSI]) irq_cause = IRQ_MSI;
      if (enabled[IRQ_MEI]) irq_cause = IRQ_MEI;
   end

   assign irq_pending = |enabled;
   assign irq_take    = irq_pending & retire & ~trap_req;
   assign mret_take   = mret & ~trap_req & ~irq_take & (priv_q == PRIV_M);

   // access legality; the write only lands when nothing of higher priority happens
   always_comb begin
      wr_bad      = csr_we & (~csr_implemented(csr_waddr) | (csr_waddr[11:4] == 8'hF1));
      csr_illegal = (priv_q == PRIV_U) | ~csr_implemented(csr_raddr) | wr_bad;
      wr_ok       = csr_we & ~wr_bad & (priv_q == PRIV_M) & ~trap_req & ~irq_take & ~mret_take;
   end

   // redirect target for traps, interrupts and mret
   always_comb begin
      base           = {mtvec_q[XLEN-1:2], 2'b00};
      redirect_valid = trap_req | irq_take | mret_take;
      redirect_pc    = base;
      if (!trap_req && irq_take && mtvec_q[0]) redirect_pc = base + {25'b0, irq_cause, 2'b00};
      else if (!trap_req && !irq_take && mret_take) redirect_pc = mepc_q;
   end

   // trap entry, mret and CSR writes, in that priority
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         priv_q     <= PRIV_M;
         st_mpp     <= PRIV_U;
         st_mie     <= 1'b0;
         st_mpie    <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mscratch_q <= '0;
      end else if (trap_req || irq_take) begin
         mepc_q   <= trap_pc & EPC_MASK;
         mcause_q <= trap_req ? {27'b0, trap_cause} : {1'b1, 26'b0, irq_cause};
         mtval_q  <= trap_req ? trap_tval : '0;
         st_mpie  <= st_mie;
         st_mie   <= 1'b0;
         st_mpp   <= priv_q;
         priv_q   <= PRIV_M;
      end else if (mret_take) begin
         st_mie  <= st_mpie;
         st_mpie <= 1'b1;
         priv_q  <= st_mpp;
         st_mpp  <= PRIV_U;
      end else if (wr_ok) begin
         case (csr_waddr)
            CSR_MSTATUS: begin
               st_mie  <= csr_wdata[MSTATUS_MIE];
               st_mpie <= csr_wdata[MSTATUS_MPIE];
               st_mpp  <= (csr_wdata[MSTATUS_MPP_LO +: 2] == 2'b11) ? PRIV_M : PRIV_U;
            end
            CSR_MIE:      mie_q      <= csr_wdata & IRQ_MASK;
            CSR_MTVEC:    mtvec_q    <= csr_wdata & MTVEC_MASK;
            CSR_MSCRATCH: mscratch_q <= csr_wdata;
            CSR_MEPC:     mepc_q     <= csr_wdata & EPC_MASK;
            CSR_MCAUSE:   mcause_q   <= csr_wdata;
            CSR_MTVAL:    mtval_q    <= csr_wdata;
            default: ;
         endcase
      end
   end

   generate
      if (HAS_COUNT) begin : g_count
         csr_counter64 u_mcycle (
            .clk   (clk),
            .nrst  (nrst),
            .inc   (1'b1),
            .we_lo (wr_ok && csr_waddr == CSR_MCYCLE),
            .we_hi (wr_ok && csr_waddr == CSR_MCYCLEH),
            .wdata (csr_wdata),
            .count (cycle)
         );
         csr_counter64 u_minstret (
            .clk   (clk),
            .nrst  (nrst),
            .inc   (retire),
            .we_lo (wr_ok && csr_waddr == CSR_MINSTRET),
            .we_hi (wr_ok && csr_waddr == CSR_MINSTRETH),
            .wdata (csr_wdata),
            .count (instret)
         );
      end else begin : g_no_count
         assign cycle   = '0;
         assign instret = '0;
      end
   endgenerate

   // combinational read port
   always_comb begin
      mstatus_rd = '0;
      mstatus_rd[MSTATUS_MIE]         = st_mie;
      mstatus_rd[MSTATUS_MPIE]        = st_mpie;
      mstatus_rd[MSTATUS_MPP_LO +: 2] = st_mpp;
      case (csr_raddr)
         CSR_MSTATUS:   csr_rdata = mstatus_rd;
         CSR_MISA:      csr_rdata = MISA_VAL;
         CSR_MIE:       csr_rdata = mie_q;
         CSR_MTVEC:     csr_rdata = mtvec_q;
         CSR_MSCRATCH:  csr_rdata = mscratch_q;
         CSR_MEPC:      csr_rdata = mepc_q;
         CSR_MCAUSE:    csr_rdata = mcause_q;
         CSR_MTVAL:     csr_rdata = mtval_q;
         CSR_MIP:       csr_rdata = mip;
         CSR_MCYCLE:    csr_rdata = cycle[31:0];
         CSR_MCYCLEH:   csr_rdata = cycle[63:32];
         CSR_MINSTRET:  csr_rdata = instret[31:0];
         CSR_MINSTRETH: csr_rdata = instret[63:32];
         default:       csr_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_csr_machine_file.sv
// Directed bench for csr_machine_file: reset, WARL, traps, interrupts, mret, counters, legality.
module tb_csr_machine_file;
   import csr_pkg::*;

   logic        clk = 1'b0;
   logic        nrst;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        retire, trap_req, mret;
   logic [4:0]  trap_cause;
   logic [31:0] trap_pc, trap_tval;
   logic        irq_ext, irq_timer, irq_soft;
   logic [3:0]  irq_local;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        irq_pending;
   mode_t       priv_mode;

   int tests = 0;
   int fails = 0;

   csr_machine_file #(.XLEN(32), .NUM_LOCAL(4), .VECTORED(1'b1), .HAS_COUNT(1'b1)) dut (
      .clk(clk), .nrst(nrst), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_illegal(csr_illegal), .csr_we(csr_we), .csr_waddr(csr_waddr),
      .csr_wdata(csr_wdata), .retire(retire), .trap_req(trap_req),
      .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
      .mret(mret), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
      .irq_local(irq_local), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .irq_pending(irq_pending), .priv_mode(priv_mode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      csr_raddr = addr;
      #1;
      check(tag, csr_rdata, exp);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data);
      csr_we = 1'b1; csr_waddr = addr; csr_wdata = data;
      step();
      csr_we = 1'b0;
   endtask

   initial begin
      nrst = 1'b0; csr_raddr = '0; csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0;
      retire = 1'b0; trap_req = 1'b0; mret = 1'b0; trap_cause = '0;
      trap_pc = '0; trap_tval = '0; irq_ext = 1'b0; irq_timer = 1'b0;
      irq_soft = 1'b0; irq_local = '0;
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;

      // reset state
      rd("rst_mstatus", CSR_MSTATUS, 32'h0);
      rd("rst_mcause", CSR_MCAUSE, 32'h0);
      rd("rst_mtvec", CSR_MTVEC, 32'h0);
      rd("misa", CSR_MISA, 32'h4010_1100);
      check("rst_priv", 32'(priv_mode), 32'h3);
      check("rst_redirect", 32'(redirect_valid), 32'h0);
      check("rst_irq_pending", 32'(irq_pending), 32'h0);
      check("rst_illegal", 32'(csr_illegal), 32'h0);

      // WARL masking
      wr(CSR_MTVEC, 32'h8000_0003);
      rd("mtvec_warl", CSR_MTVEC, 32'h8000_0001);
      wr(CSR_MIE, 32'hFFFF_FFFF);
      rd("mie_warl", CSR_MIE, 32'h000F_0888);
      wr(CSR_MSTATUS, 32'h0000_0888);
      rd("mstatus_mpp01", CSR_MSTATUS, 32'h0000_0088);
      wr(CSR_MIE, 32'h0000_0800);
      wr(CSR_MSTATUS, 32'h0000_0008);
      rd("mstatus_mie", CSR_MSTATUS, 32'h0000_0008);

      // external interrupt, vectored
      irq_ext = 1'b1; #1;
      check("irq_pending_ext", 32'(irq_pending), 32'h1);
      retire = 1'b1; trap_pc = 32'h0000_0200; #1;
      check("irq_redirect_valid", 32'(redirect_valid), 32'h1);
      check("irq_redirect_pc", redirect_pc, 32'h8000_002C);
      step();
      retire = 1'b0; irq_ext = 1'b0;
      rd("irq_mcause", CSR_MCAUSE, 32'h8000_000B);
      rd("irq_mstatus", CSR_MSTATUS, 32'h0000_1880);
      rd("irq_mepc", CSR_MEPC, 32'h0000_0200);
      rd("irq_mtval", CSR_MTVAL, 32'h0);

      // mret into U-mode, then an exception back to M
      wr(CSR_MSTATUS, 32'h0000_0080);
      wr(CSR_MEPC, 32'h0000_1003);
      rd("mepc_warl", CSR_MEPC, 32'h0000_1000);
      mret = 1'b1; #1;
      check("mret_redirect_valid", 32'(redirect_valid), 32'h1);
      check("mret_redirect_pc", redirect_pc, 32'h0000_1000);
      step();
      mret = 1'b0;
      check("mret_priv", 32'(priv_mode), 32'h0);
      rd("u_read_illegal", CSR_MSTATUS, 32'h0000_0088);
      check("u_illegal_flag", 32'(csr_illegal), 32'h1);
      wr(CSR_MSCRATCH, 32'h0000_00AA);
      trap_req = 1'b1; trap_cause = 5'd2; trap_pc = 32'h0000_0100; trap_tval = 32'h0000_1234; #1;
      check("exc_redirect_pc", redirect_pc, 32'h8000_0000);
      step();
      trap_req = 1'b0;
      check("exc_priv", 32'(priv_mode), 32'h3);
      rd("exc_mepc", CSR_MEPC, 32'h0000_0100);
      rd("exc_mcause", CSR_MCAUSE, 32'h0000_0002);
      rd("exc_mtval", CSR_MTVAL, 32'h0000_1234);
      rd("exc_mstatus", CSR_MSTATUS, 32'h0000_0080);
      rd("u_write_dropped", CSR_MSCRATCH, 32'h0);

      // trap beats a same-cycle CSR write
      trap_req = 1'b1; trap_cause = 5'd5; trap_pc = 32'h0000_0300; trap_tval = 32'h0;
      wr(CSR_MSCRATCH, 32'h0000_0055);
      trap_req = 1'b0;
      rd("trapwr_mscratch", CSR_MSCRATCH, 32'h0);
      rd("trapwr_mcause", CSR_MCAUSE, 32'h0000_0005);
      rd("trapwr_mepc", CSR_MEPC, 32'h0000_0300);
      rd("trapwr_mstatus", CSR_MSTATUS, 32'h0000_1800);

      // counter carry and retire counting
      wr(CSR_MCYCLE, 32'hFFFF_FFFF);
      wr(CSR_MCYCLEH, 32'h0);
      step();
      step();
      csr_raddr = CSR_MCYCLEH; #0;
      check("mcycleh_carry", csr_rdata, 32'h1);
      csr_raddr = CSR_MCYCLE; #0;
      check("mcycle_after", csr_rdata, 32'h1);
      wr(CSR_MINSTRET, 32'h5);
      retire = 1'b1;
      repeat (3) step();
      retire = 1'b0;
      rd("minstret", CSR_MINSTRET, 32'h8);

      // priority: MSI over MTI and local; then highest local index
      wr(CSR_MIE, 32'hFFFF_FFFF);
      irq_soft = 1'b1; irq_timer = 1'b1; irq_local = 4'b1111;
      wr(CSR_MSTATUS, 32'h0000_0008);
      rd("mip_live", CSR_MIP, 32'h000F_0088);
      retire = 1'b1; trap_pc = 32'h0000_0400; #1;
      check("msi_redirect_pc", redirect_pc, 32'h8000_000C);
      step();
      retire = 1'b0;
      rd("msi_mcause", CSR_MCAUSE, 32'h8000_0003);
      check("pending_masked", 32'(irq_pending), 32'h0);
      irq_soft = 1'b0; irq_timer = 1'b0;
      wr(CSR_MSTATUS, 32'h0000_0008);
      retire = 1'b1; #1;
      check("local_redirect_pc", redirect_pc, 32'h8000_004C);
      step();
      retire = 1'b0; irq_local = '0;
      rd("local_mcause", CSR_MCAUSE, 32'h8000_0013);

      // read-only write and unimplemented read
      csr_raddr = CSR_MISA;
      csr_we = 1'b1; csr_waddr = CSR_MVENDORID; csr_wdata = 32'hDEAD_BEEF; #1;
      check("ro_write_illegal", 32'(csr_illegal), 32'h1);
      step();
      csr_we = 1'b0;
      rd("mvendorid", CSR_MVENDORID, 32'h0);
      rd("unimpl_read", 12'h7C0, 32'h0);
      check("unimpl_illegal", 32'(csr_illegal), 32'h1);

      // asynchronous reset in the middle of a trap
      trap_req = 1'b1; trap_cause = 5'd7; trap_pc = 32'h0000_0700;
      #2 nrst = 1'b0;
      #1;
      trap_req = 1'b0;
      rd("abort_mcause", CSR_MCAUSE, 32'h0);
      rd("abort_mepc", CSR_MEPC, 32'h0);
      check("abort_priv", 32'(priv_mode), 32'h3);
      step();
      nrst = 1'b1;
      step();
      rd("abort_mcause_post", CSR_MCAUSE, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
